mm_iter_ctrl: RTL and testbench
===============================

MM_ITER_CTRL -- requirements
Module: mm_iter_ctrl

Interface
REQ-001 SHALL have parameter: TAG_W, 4, width of request tag carried to the result.
REQ-002 SHALL have port: clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operation request.
REQ-005 SHALL have port: in_ready  output  1  controller can accept a request.
REQ-006 SHALL have port: in_a  input  256  multiplier operand A, Montgomery domain, < M.
REQ-007 SHALL have port: in_b  input  256  multiplicand operand B, Montgomery domain, < M.
REQ-008 SHALL have port: in_tag  input  TAG_W  requester tag.
REQ-009 SHALL have port: out_valid  output  1  result available.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: out_result  output  256  A*B*2^-256 mod M.
REQ-012 SHALL have port: out_tag  output  TAG_W  tag of the returned result.
REQ-013 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ITER, DONE; reset state IDLE.
REQ-015 SHALL assert in_ready in IDLE, and in DONE when out_ready is high; low in ITER.
REQ-016 SHALL, on in_valid&&in_ready, latch in_a, in_b, in_tag, clear digit counter cnt to 0, enter ITER.
REQ-017 SHALL keep latched operands stable throughout ITER; input port changes SHALL have no effect.
REQ-018 SHALL run ITER for exactly 5 cycles, cnt = 0..4, then enter DONE.
REQ-019 SHALL drive the datapath per ITER cycle: op1 = A[64*cnt +: 64] for cnt 0..3; op2 = B throughout.
REQ-020 SHALL drive datapath sel = 0 at cnt 0 and sel = 1 at cnt 1..4, so the accumulator starts from zero.
REQ-021 SHALL drive datapath vld = 1 only at cnt 4 (final shift cycle, op1 forced to zero); vld = 0 elsewhere.
REQ-022 SHALL drive sel = 0, vld = 0, op1 = 0 outside ITER.
REQ-023 SHALL capture the datapath 256-bit result into a result register on the clock edge ending cnt 4.
REQ-024 SHALL assert out_valid throughout DONE, with out_result and out_tag stable until out_valid&&out_ready.
REQ-025 SHALL set latency: acceptance edge E0 gives out_valid high after edge E0+5.
REQ-026 SHALL, on out_valid&&out_ready without a new acceptance, return to IDLE the next cycle.
REQ-027 SHALL, on out_valid&&out_ready with in_valid high in the same cycle, accept the new request and enter ITER directly, with no idle bubble.
REQ-028 SHALL ignore out_ready in IDLE and ITER.
REQ-029 SHALL leave out_result and out_tag at their last captured values outside DONE; out_valid = 0 there.
REQ-030 SHALL keep busy = (state != IDLE).

Reset
REQ-031 SHALL, on rst_n low at any time including mid-ITER, clear asynchronously: state to IDLE, cnt, operands, tag, out_result, out_tag to 0.
REQ-032 SHALL reset outputs to: in_ready = 1 (IDLE), out_valid = 0, busy = 0, out_result = 0, out_tag = 0.
REQ-033 SHALL, because datapath accumulator reset is tied to the same rst_n, drop any aborted operation and produce no result for it.

Structure
REQ-034 SHALL take from the shared package: modulus M, DIGIT_W = 64, N_DIGITS = 4, ITER_CYCLES = 5, the state enum, and constant R_MOD_M = 2^256 mod M.
REQ-035 SHALL instantiate exactly one sub-module, the existing mm_256x256_iter datapath, sharing clk and rst_n.

Verification
REQ-036 SHALL cover: A = 0, B = R_MOD_M, tag 3 -> out_result 0, out_tag 3, out_valid 5 cycles after acceptance.
REQ-037 SHALL cover: A = B = R_MOD_M -> out_result R_MOD_M (one times one).
REQ-038 SHALL cover: A = 1, B = (R^2 mod M) -> out_result R_MOD_M; 200 random A, B < M checked against a reference model A*B*2^-256 mod M.
REQ-039 SHALL cover: out_ready held low 10 cycles in DONE -> out_valid, out_result, out_tag stable; in_ready 0; no new acceptance.
REQ-040 SHALL cover: back-to-back requests with out_ready = 1 -> second acceptance in the same cycle as the first handshake, one result every 6 cycles, tags in order.
REQ-041 SHALL cover: rst_n pulsed low at cnt 2 -> immediate IDLE, out_valid 0; the next request yields the correct result.

Source files
------------

// File: rtl/mm_iter_ctrl_pkg.sv
// Shared constants and types for the word-serial 256-bit Montgomery multiplier.
// Modulus is the secp256k1 field prime; R = 2^256.
package mm_iter_ctrl_pkg;

    localparam int OP_W        = 256;
    localparam int DIGIT_W     = 64;
    localparam int N_DIGITS    = 4;
    localparam int ITER_CYCLES = 5;

    localparam logic [OP_W-1:0] M =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [OP_W-1:0] R_MOD_M = 256'h1_000003D1;

    // -M^-1 mod 2^64 by Newton iteration; an odd m is its own inverse mod 8,
    // and each step doubles the number of correct low bits (3 -> 96).
    function automatic logic [DIGIT_W-1:0] neg_inv_digit(input logic [DIGIT_W-1:0] m0);
        logic [DIGIT_W-1:0] x;
        x = m0;
        for (int i = 0; i < 5; i++) begin
            x = x * (64'd2 - m0 * x);
        end
        return -x;
    endfunction

    localparam logic [DIGIT_W-1:0] M_PRIME = neg_inv_digit(M[DIGIT_W-1:0]);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mm_256x256_iter.sv
// Montgomery datapath: one 64-bit digit of A per cycle against the full B,
// with a final conditional subtraction presented on result when vld is high.
module mm_256x256_iter
    import mm_iter_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sel,
    input  logic               vld,
    input  logic [DIGIT_W-1:0] op1,
    input  logic [OP_W-1:0]    op2,
    output logic [OP_W-1:0]    result
);

    // Accumulator stays below 2M, which needs one bit above OP_W; the
    // partial sum acc + a_i*B + q*M needs two digits of headroom plus carry.
    localparam int ACC_W = OP_W + 1;
    localparam int DP_W  = OP_W + 2 * DIGIT_W + 2;

    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [DP_W-1:0]    t;
    logic [DIGIT_W-1:0] q;

    always_comb begin
        t      = (sel ? DP_W'(acc_q) : '0) + DP_W'(op1) * DP_W'(op2);
        q      = DIGIT_W'(t) * M_PRIME;
        acc_d  = ACC_W'((t + DP_W'(q) * DP_W'(M)) >> DIGIT_W);
        result = vld ? OP_W'((acc_q >= ACC_W'(M)) ? acc_q - ACC_W'(M) : acc_q) : '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/mm_iter_ctrl.sv
// Sequencing controller for the iterative Montgomery multiplier: accepts one
// request, feeds digits of A for five cycles, then holds the result until taken.
module mm_iter_ctrl
    import mm_iter_ctrl_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OP_W-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int               CNT_W     = $clog2(ITER_CYCLES);
    localparam int               DIG_IDX_W = $clog2(N_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(ITER_CYCLES - 1);

    state_t                           state_q;
    state_t                           state_d;
    logic [CNT_W-1:0]                 cnt_q;
    logic [N_DIGITS-1:0][DIGIT_W-1:0] a_q;
    logic [OP_W-1:0]                  b_q;
    logic [TAG_W-1:0]                 tag_q;
    logic [OP_W-1:0]                  result_q;
    logic [TAG_W-1:0]                 out_tag_q;

    logic               accept;
    logic               dp_sel;
    logic               dp_vld;
    logic [DIGIT_W-1:0] dp_op1;
    logic [OP_W-1:0]    dp_result;

    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != IDLE);
        dp_sel    = 1'b0;
        dp_vld    = 1'b0;
        dp_op1    = '0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ITER;
            end
            ITER: begin
                dp_sel = (cnt_q != '0);
                if (cnt_q == CNT_LAST) begin
                    dp_vld  = 1'b1;
                    state_d = DONE;
                end else begin
                    dp_op1 = a_q[cnt_q[DIG_IDX_W-1:0]];
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_d = in_valid ? ITER : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            tag_q     <= '0;
            result_q  <= '0;
            out_tag_q <= '0;
        end else begin
            if (accept) begin
                a_q   <= in_a;
                b_q   <= in_b;
                tag_q <= in_tag;
                cnt_q <= '0;
            end else if (state_q == ITER && cnt_q != CNT_LAST) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (dp_vld) begin
                result_q  <= dp_result;
                out_tag_q <= tag_q;
            end
        end
    end

    mm_256x256_iter u_datapath (
        .clk    (clk),
        .rst_n  (rst_n),
        .sel    (dp_sel),
        .vld    (dp_vld),
        .op1    (dp_op1),
        .op2    (b_q),
        .result (dp_result)
    );

    assign out_result = result_q;
    assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_mm_iter_ctrl.sv
// Directed bench for mm_iter_ctrl: reset, latency, hold, back-to-back, abort
// and random products against an independent modular reference.
module tb_mm_iter_ctrl;

    localparam logic [255:0] MOD =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] R1 = 256'h1_000003D1;
    localparam logic [255:0] R2 = 256'h1_000007A2_000E90A1;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_a;
    logic [255:0] in_b;
    logic [3:0]   in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_result;
    logic [3:0]   out_tag;
    logic         busy;

    int total;
    int bad;
    int cyc;

    mm_iter_ctrl #(.TAG_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // (a*b mod M) followed by 256 modular halvings gives a*b*2^-256 mod M.
    function automatic logic [255:0] mont_ref(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] p;
        logic [256:0] x;
        p = ({256'd0, a} * {256'd0, b}) % {256'd0, MOD};
        x = p[256:0];
        for (int i = 0; i < 256; i++) begin
            x = x[0] ? ((x + {1'b0, MOD}) >> 1) : (x >> 1);
        end
        return x[255:0];
    endfunction

    function automatic logic [255:0] rand_op();
        logic [255:0] v;
        v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if (v >= MOD) v = v - MOD;
        return v;
    endfunction

    // Called at posedge+1 with the controller ready; returns at posedge+1 of
    // the acceptance edge with the inputs scrambled to prove they are latched.
    task automatic start_op(input logic [255:0] a, input logic [255:0] b, input logic [3:0] tag);
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
        in_tag   = ~tag;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input string name, input logic [255:0] a, input logic [255:0] b,
                          input logic [3:0] tag, input logic [255:0] exp);
        int n;
        start_op(a, b, tag);
        check($sformatf("%s/in_ready_iter", name), 256'(in_ready), 256'd0);
        wait_valid(n);
        check($sformatf("%s/latency", name), 256'(n), 256'd5);
        check($sformatf("%s/result", name), out_result, exp);
        check($sformatf("%s/tag", name), 256'(out_tag), 256'(tag));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check($sformatf("%s/valid_after", name), 256'(out_valid), 256'd0);
        check($sformatf("%s/busy_after", name), 256'(busy), 256'd0);
        check($sformatf("%s/result_held", name), out_result, exp);
    endtask

    initial begin
        logic [255:0] ra;
        logic [255:0] rb;
        logic [255:0] bb_a [3];
        logic [255:0] bb_b [3];
        logic [255:0] bb_e [3];
        logic [3:0]   bb_t [3];
        int           n;
        int           last_cyc;

        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b0;

        #3;
        check("rst/in_ready", 256'(in_ready), 256'd1);
        check("rst/out_valid", 256'(out_valid), 256'd0);
        check("rst/busy", 256'(busy), 256'd0);
        check("rst/out_result", out_result, 256'd0);
        check("rst/out_tag", 256'(out_tag), 256'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // out_ready is meaningless in IDLE
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle/out_ready_busy", 256'(busy), 256'd0);
        check("idle/out_ready_valid", 256'(out_valid), 256'd0);
        out_ready = 1'b0;

        run_op("zero_a", 256'd0, R1, 4'd3, 256'd0);
        run_op("one_one", R1, R1, 4'd4, R1);
        run_op("one_r2", 256'd1, R2, 4'd5, R1);
        run_op("max_ops", MOD - 1, MOD - 1, 4'd15, mont_ref(MOD - 1, MOD - 1));

        // Result held while the consumer stalls; new requests are refused.
        start_op(R1, R1, 4'd9);
        wait_valid(n);
        check("hold/latency", 256'(n), 256'd5);
        in_a     = R2;
        in_b     = R2;
        in_tag   = 4'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold/valid%0d", i), 256'(out_valid), 256'd1);
            check($sformatf("hold/result%0d", i), out_result, R1);
            check($sformatf("hold/tag%0d", i), 256'(out_tag), 256'd9);
            check($sformatf("hold/in_ready%0d", i), 256'(in_ready), 256'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hold/idle_after", 256'(busy), 256'd0);
        check("hold/tag_kept", 256'(out_tag), 256'd9);

        // Back-to-back: each handshake edge also accepts the next request.
        bb_a[0] = R1;     bb_b[0] = R1;    bb_e[0] = R1;     bb_t[0] = 4'd6;
        bb_a[1] = 256'd1; bb_b[1] = R2;    bb_e[1] = R1;     bb_t[1] = 4'd7;
        bb_a[2] = 256'd0; bb_b[2] = R2;    bb_e[2] = 256'd0; bb_t[2] = 4'd8;
        out_ready = 1'b1;
        in_a      = bb_a[0];
        in_b      = bb_b[0];
        in_tag    = bb_t[0];
        in_valid  = 1'b1;
        @(posedge clk); #1;
        last_cyc = 0;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) begin
                in_a   = bb_a[i+1];
                in_b   = bb_b[i+1];
                in_tag = bb_t[i+1];
            end else begin
                in_valid = 1'b0;
            end
            wait_valid(n);
            check($sformatf("b2b%0d/latency", i), 256'(n), 256'd5);
            if (i > 0) check($sformatf("b2b%0d/period", i), 256'(cyc - last_cyc), 256'd6);
            last_cyc = cyc;
            check($sformatf("b2b%0d/result", i), out_result, bb_e[i]);
            check($sformatf("b2b%0d/tag", i), 256'(out_tag), 256'(bb_t[i]));
            check($sformatf("b2b%0d/in_ready", i), 256'(in_ready), 256'd1);
            @(posedge clk); #1;
            check($sformatf("b2b%0d/valid_drop", i), 256'(out_valid), 256'd0);
            check($sformatf("b2b%0d/busy_next", i), 256'(busy), (i < 2) ? 256'd1 : 256'd0);
        end
        out_ready = 1'b0;

        // Abort at cnt 2: asynchronous clear, no result for the dropped request.
        start_op(R2, R2, 4'd10);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        check("abort/busy", 256'(busy), 256'd0);
        check("abort/out_valid", 256'(out_valid), 256'd0);
        check("abort/in_ready", 256'(in_ready), 256'd1);
        check("abort/out_result", out_result, 256'd0);
        check("abort/out_tag", 256'(out_tag), 256'd0);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abort/no_result", 256'(out_valid), 256'd0);
        run_op("after_abort", R1, R1, 4'd11, R1);

        for (int i = 0; i < 200; i++) begin
            ra = rand_op();
            rb = rand_op();
            run_op($sformatf("rand%0d", i), ra, rb, 4'(i), mont_ref(ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
